axi_reg_word_wr: RTL and testbench
==================================

// Module: axi_reg_word_wr
// PURPOSE
//  AXI4 write-channel slave. Converts AW/W/B traffic into a single-cycle word-write strobe for user_plugin register files.
//  Write-side companion of the word read adapter; both share word_addr decoding (ARADDR/AWADDR bits [WORD_ADDR_WIDTH+1:2]).
//  One transaction at a time, no outstanding writes. Every beat of a burst writes the word at AWADDR.
// PARAMETERS
//  AXI4_ADDR_WIDTH  32              AW address width
//  AXI4_DATA_WIDTH  32              W data width
//  AXI4_ID_WIDTH    16              AWID/BID width
//  AXI4_USER_WIDTH  10              AWUSER/WUSER/BUSER width
//  AXI_STRB_WIDTH   DATA_WIDTH/8    WSTRB width
//  WORD_ADDR_WIDTH  4               register word-index width
// PORTS
//  ACLK          in   1         clock
//  ARESETn       in   1         async reset, active low
//  AWID_i        in   ID        write ID, latched on AW handshake
//  AWADDR_i      in   ADDR      byte address; bits [WORD_ADDR_WIDTH+1:2] used
//  AWLEN_i       in   8         beats-1
//  AWSIZE_i,AWBURST_i,AWLOCK_i,AWCACHE_i,AWPROT_i,AWREGION_i,AWUSER_i,AWQOS_i  in  std AXI widths  accepted, ignored
//  AWVALID_i     in   1         AW valid
//  AWREADY_o     out  1         AW ready
//  WDATA_i       in   DATA      write data
//  WSTRB_i       in   STRB      byte strobes
//  WLAST_i       in   1         last beat (see CONFIGURATION)
//  WUSER_i       in   USER      ignored
//  WVALID_i      in   1         W valid
//  WREADY_o      out  1         W ready
//  BID_o         out  ID        = latched AWID
//  BRESP_o       out  2         response
//  BUSER_o       out  USER      constant 0
//  BVALID_o      out  1         B valid
//  BREADY_i      in   1         B ready
//  we_o          out  1         word write strobe, one cycle per accepted W beat
//  word_addr_o   out  WORD_ADDR latched word index; valid whenever we_o=1
//  wdata_o       out  DATA      = WDATA_i, valid when we_o=1
//  wstrb_o       out  STRB      = WSTRB_i, valid when we_o=1
// BEHAVIOUR
//  FSM: WAIT_AWVALID -> WRITE_DATA -> SEND_BRESP -> WAIT_AWVALID. Handshake outputs decode combinationally from state.
//  WAIT_AWVALID: AWREADY_o=1, WREADY_o=0. On AWVALID_i: latch AWID, word addr, AWLEN into r_awlen -> WRITE_DATA.
//  W arriving before or together with AW is stalled (WREADY_o=0) until the cycle after the AW handshake.
//  WRITE_DATA: WREADY_o=1, AWREADY_o=0. Each cycle with WVALID_i=1: we_o=1 in the same cycle (comb from WVALID_i).
//    r_awlen==0 -> SEND_BRESP; otherwise r_awlen decrements, stay.
//  SEND_BRESP: BVALID_o=1, hold BID/BRESP stable until BREADY_i; on BREADY_i -> WAIT_AWVALID.
//  Latency: AW at cycle N -> first beat accepted earliest at N+1. Last beat at M -> BVALID_o at M+1. Single beat = 3 cycles min.
//  AWLEN=255 -> 256 beats, all to the same word. No wrap of the word address.
//  AWVALID during WRITE_DATA or SEND_BRESP is not accepted until WAIT_AWVALID is re-entered.
//  Reset (asserted or mid-transaction): state=WAIT_AWVALID, r_awlen=0, BID_o=0, BRESP_o=OKAY.
//    AWREADY_o=1, WREADY_o=0, BVALID_o=0, we_o=0. A pending B is dropped and no further we_o is issued.
// CONFIGURATION
//  AXI_REG_WR_LAST_CHECK_EN defined:
//    sticky error flag, set when WLAST_i on an accepted beat != (r_awlen==0). Flag clears on AW handshake.
//    BRESP_o=SLVERR if set, else OKAY. Beat count is still governed by AWLEN, and every beat still drives we_o.
//  Not defined: WLAST_i ignored, BRESP_o always OKAY.
// TESTING
//  1 single write: AWADDR=0x0C, AWLEN=0, WDATA=0xDEADBEEF, WSTRB=0xF -> we_o 1 cycle, word_addr_o=3; BVALID next cycle, BRESP=OKAY, BID=AWID.
//  2 burst: AWLEN=3, WVALID toggled 1/0 -> exactly 4 we_o pulses at word_addr_o; BVALID only after 4th beat.
//  3 B backpressure: BREADY=0 for 5 cycles -> BVALID/BID held stable, AWREADY=0, no we_o; BREADY=1 -> WAIT_AWVALID next cycle.
//  4 simultaneous AWVALID+WVALID: WREADY=0 in the AW cycle, beat accepted the following cycle. WSTRB=0x5 passed to wstrb_o.
//  5 reset mid-burst: AWLEN=7, ARESETn low after beat 2 -> we_o=0, BVALID=0, AWREADY=1. Next write completes normally.
//  6 with AXI_REG_WR_LAST_CHECK_EN: AWLEN=1, WLAST=1 on beat 0 -> 2 we_o pulses, BRESP=SLVERR. Next clean write -> OKAY.

Source files
------------

// File: rtl/axi_reg_word_wr_if.sv
// ---------------------------------------------------------------------------
// axi_reg_word_wr_if
//   AXI4 write-channel bundle (AW, W and B) for axi_reg_word_wr.
//   Signal names carry the slave-side direction suffix (_i into the slave,
//   _o out of the slave) so they read the same as the original port list.
//   Modports:
//     slave  - used by axi_reg_word_wr
//     master - used by whatever drives the write channel
// ---------------------------------------------------------------------------
interface axi_reg_word_wr_if #(
    parameter int unsigned AXI4_ADDR_WIDTH = 32,
    parameter int unsigned AXI4_DATA_WIDTH = 32,
    parameter int unsigned AXI4_ID_WIDTH   = 16,
    parameter int unsigned AXI4_USER_WIDTH = 10,
    parameter int unsigned AXI_STRB_WIDTH  = AXI4_DATA_WIDTH / 8
);
    // AW channel
    logic [AXI4_ID_WIDTH-1:0]   AWID_i;
    logic [AXI4_ADDR_WIDTH-1:0] AWADDR_i;
    logic [7:0]                 AWLEN_i;
    logic [2:0]                 AWSIZE_i;
    logic [1:0]                 AWBURST_i;
    logic                       AWLOCK_i;
    logic [3:0]                 AWCACHE_i;
    logic [2:0]                 AWPROT_i;
    logic [3:0]                 AWREGION_i;
    logic [AXI4_USER_WIDTH-1:0] AWUSER_i;
    logic [3:0]                 AWQOS_i;
    logic                       AWVALID_i;
    logic                       AWREADY_o;
    // W channel
    logic [AXI4_DATA_WIDTH-1:0] WDATA_i;
    logic [AXI_STRB_WIDTH-1:0]  WSTRB_i;
    logic                       WLAST_i;
    logic [AXI4_USER_WIDTH-1:0] WUSER_i;
    logic                       WVALID_i;
    logic                       WREADY_o;
    // B channel
    logic [AXI4_ID_WIDTH-1:0]   BID_o;
    logic [1:0]                 BRESP_o;
    logic [AXI4_USER_WIDTH-1:0] BUSER_o;
    logic                       BVALID_o;
    logic                       BREADY_i;

    modport slave (
        input  AWID_i, AWADDR_i, AWLEN_i, AWSIZE_i, AWBURST_i, AWLOCK_i,
               AWCACHE_i, AWPROT_i, AWREGION_i, AWUSER_i, AWQOS_i, AWVALID_i,
        output AWREADY_o,
        input  WDATA_i, WSTRB_i, WLAST_i, WUSER_i, WVALID_i,
        output WREADY_o,
        output BID_o, BRESP_o, BUSER_o, BVALID_o,
        input  BREADY_i
    );

    modport master (
        output AWID_i, AWADDR_i, AWLEN_i, AWSIZE_i, AWBURST_i, AWLOCK_i,
               AWCACHE_i, AWPROT_i, AWREGION_i, AWUSER_i, AWQOS_i, AWVALID_i,
        input  AWREADY_o,
        output WDATA_i, WSTRB_i, WLAST_i, WUSER_i, WVALID_i,
        input  WREADY_o,
        input  BID_o, BRESP_o, BUSER_o, BVALID_o,
        output BREADY_i
    );
endinterface

// File: rtl/axi_reg_word_wr.sv
// ---------------------------------------------------------------------------
// axi_reg_word_wr
//   AXI4 write-channel slave that turns AW/W/B traffic into a single-cycle
//   word-write strobe for a register file. One transaction at a time; every
//   beat of a burst writes the word selected by AWADDR[WORD_ADDR_WIDTH+1:2].
//
//   Ports:
//     ACLK, ARESETn  clock, asynchronous active-low reset
//     s_axi          AXI4 AW/W/B channels (axi_reg_word_wr_if.slave)
//     we_o           one-cycle write strobe per accepted W beat
//     word_addr_o    latched word index, valid while we_o=1
//     wdata_o        W data pass-through, valid while we_o=1
//     wstrb_o        W strobe pass-through, valid while we_o=1
//
//   Optional feature: define AXI_REG_WR_LAST_CHECK_EN to check WLAST against
//   the AWLEN beat count; a mismatch answers SLVERR instead of OKAY.
// ---------------------------------------------------------------------------
module axi_reg_word_wr #(
    parameter int unsigned AXI4_ADDR_WIDTH = 32,
    parameter int unsigned AXI4_DATA_WIDTH = 32,
    parameter int unsigned AXI4_ID_WIDTH   = 16,
    parameter int unsigned AXI4_USER_WIDTH = 10,
    parameter int unsigned AXI_STRB_WIDTH  = AXI4_DATA_WIDTH / 8,
    parameter int unsigned WORD_ADDR_WIDTH = 4
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    axi_reg_word_wr_if.slave           s_axi,
    output logic                       we_o,
    output logic [WORD_ADDR_WIDTH-1:0] word_addr_o,
    output logic [AXI4_DATA_WIDTH-1:0] wdata_o,
    output logic [AXI_STRB_WIDTH-1:0]  wstrb_o
);

    typedef enum logic [1:0] {
        WAIT_AWVALID,
        WRITE_DATA,
        SEND_BRESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t                     state_q, state_d;
    logic [7:0]                 awlen_q, awlen_d;
    logic [AXI4_ID_WIDTH-1:0]   bid_q, bid_d;
    logic [WORD_ADDR_WIDTH-1:0] word_addr_q, word_addr_d;

    logic awready, wready, bvalid, we;

`ifdef AXI_REG_WR_LAST_CHECK_EN
    logic err_q, err_d;
`endif

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= WAIT_AWVALID;
            awlen_q     <= '0;
            bid_q       <= '0;
            word_addr_q <= '0;
`ifdef AXI_REG_WR_LAST_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            awlen_q     <= awlen_d;
            bid_q       <= bid_d;
            word_addr_q <= word_addr_d;
`ifdef AXI_REG_WR_LAST_CHECK_EN
            err_q       <= err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        awlen_d     = awlen_q;
        bid_d       = bid_q;
        word_addr_d = word_addr_q;
`ifdef AXI_REG_WR_LAST_CHECK_EN
        err_d       = err_q;
`endif
        awready     = 1'b0;
        wready      = 1'b0;
        bvalid      = 1'b0;
        we          = 1'b0;

        unique case (state_q)
            WAIT_AWVALID: begin
                awready = 1'b1;
                if (s_axi.AWVALID_i) begin
                    bid_d       = s_axi.AWID_i;
                    word_addr_d = s_axi.AWADDR_i[WORD_ADDR_WIDTH+1:2];
                    awlen_d     = s_axi.AWLEN_i;
`ifdef AXI_REG_WR_LAST_CHECK_EN
                    err_d       = 1'b0;
`endif
                    state_d     = WRITE_DATA;
                end
            end

            WRITE_DATA: begin
                wready = 1'b1;
                if (s_axi.WVALID_i) begin
                    // awlen_q counts remaining beats; zero marks the final one.
                    we = 1'b1;
`ifdef AXI_REG_WR_LAST_CHECK_EN
                    if (s_axi.WLAST_i != (awlen_q == 8'd0)) begin
                        err_d = 1'b1;
                    end
`endif
                    if (awlen_q == 8'd0) begin
                        state_d = SEND_BRESP;
                    end else begin
                        awlen_d = awlen_q - 8'd1;
                    end
                end
            end

            SEND_BRESP: begin
                bvalid = 1'b1;
                if (s_axi.BREADY_i) begin
                    state_d = WAIT_AWVALID;
                end
            end

            default: begin
                state_d = WAIT_AWVALID;
            end
        endcase
    end

    assign s_axi.AWREADY_o = awready;
    assign s_axi.WREADY_o  = wready;
    assign s_axi.BVALID_o  = bvalid;
    assign s_axi.BID_o     = bid_q;
    assign s_axi.BUSER_o   = '0;

`ifdef AXI_REG_WR_LAST_CHECK_EN
    assign s_axi.BRESP_o = err_q ? RESP_SLVERR : RESP_OKAY;
`else
    assign s_axi.BRESP_o = RESP_OKAY;
`endif

    assign we_o        = we;
    assign word_addr_o = word_addr_q;
    assign wdata_o     = s_axi.WDATA_i;
    assign wstrb_o     = s_axi.WSTRB_i;

    // Sideband AXI fields are accepted but carry no meaning for a word register.
    logic unused_inputs;
`ifdef AXI_REG_WR_LAST_CHECK_EN
    assign unused_inputs = ^{s_axi.AWADDR_i, s_axi.AWSIZE_i, s_axi.AWBURST_i,
                             s_axi.AWLOCK_i, s_axi.AWCACHE_i, s_axi.AWPROT_i,
                             s_axi.AWREGION_i, s_axi.AWUSER_i, s_axi.AWQOS_i,
                             s_axi.WUSER_i, RESP_SLVERR};
`else
    assign unused_inputs = ^{s_axi.AWADDR_i, s_axi.AWSIZE_i, s_axi.AWBURST_i,
                             s_axi.AWLOCK_i, s_axi.AWCACHE_i, s_axi.AWPROT_i,
                             s_axi.AWREGION_i, s_axi.AWUSER_i, s_axi.AWQOS_i,
                             s_axi.WUSER_i, s_axi.WLAST_i, RESP_SLVERR};
`endif

endmodule

// File: tb/tb_axi_reg_word_wr.sv
module tb_axi_reg_word_wr;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic        we;
    logic [3:0]  word_addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    axi_reg_word_wr_if #(
        .AXI4_ADDR_WIDTH(32),
        .AXI4_DATA_WIDTH(32),
        .AXI4_ID_WIDTH  (16),
        .AXI4_USER_WIDTH(10),
        .AXI_STRB_WIDTH (4)
    ) bus ();

    axi_reg_word_wr #(
        .AXI4_ADDR_WIDTH(32),
        .AXI4_DATA_WIDTH(32),
        .AXI4_ID_WIDTH  (16),
        .AXI4_USER_WIDTH(10),
        .AXI_STRB_WIDTH (4),
        .WORD_ADDR_WIDTH(4)
    ) dut (
        .ACLK       (clk),
        .ARESETn    (rst_n),
        .s_axi      (bus),
        .we_o       (we),
        .word_addr_o(word_addr),
        .wdata_o    (wdata),
        .wstrb_o    (wstrb)
    );

    // Reference: response expected for a burst given whether any beat's WLAST
    // disagreed with "this is beat number AWLEN".
    function automatic logic [1:0] model_bresp(input bit last_mismatch);
`ifdef AXI_REG_WR_LAST_CHECK_EN
        return last_mismatch ? 2'b10 : 2'b00;
`else
        return 2'b00;
`endif
    endfunction

    // Reference: register word selected by a byte address.
    function automatic logic [3:0] model_word(input logic [31:0] addr);
        return addr[5:2];
    endfunction

    // Drives one complete write transaction starting one time unit after a
    // rising edge in the idle state, and ends the same way.
    task automatic run_write(input logic [15:0] id, input logic [31:0] addr,
                             input int unsigned len, input int err_beat,
                             input int unsigned gap_pct, input int unsigned bready_delay,
                             input bit simul, input string tag);
        int unsigned beat = 0;
        int unsigned cyc  = 0;
        bit          wv;
        bit          first;
        bit          mism = 1'b0;
        logic [31:0] d;
        logic [3:0]  s;
        logic [1:0]  eresp;

        d = $urandom;
        s = simul ? 4'h5 : 4'($urandom);
        bus.AWID_i    = id;
        bus.AWADDR_i  = addr;
        bus.AWLEN_i   = 8'(len);
        bus.AWSIZE_i  = 3'($urandom);
        bus.AWUSER_i  = 10'($urandom);
        bus.AWVALID_i = 1'b1;
        bus.WVALID_i  = simul;
        bus.WDATA_i   = d;
        bus.WSTRB_i   = s;
        bus.WLAST_i   = (len == 0) ^ (err_beat == 0);
        @(negedge clk);
        n_checks++;
        if (bus.AWREADY_o !== 1'b1) begin
            n_errors++; $display("FAIL %s aw_awready: got %b want 1", tag, bus.AWREADY_o);
        end
        n_checks++;
        if (bus.WREADY_o !== 1'b0 || we !== 1'b0) begin
            n_errors++; $display("FAIL %s aw_wstall: wready %b we %b want 0 0", tag, bus.WREADY_o, we);
        end
        @(posedge clk); #1;
        // Scramble AW fields: the slave must use the latched copies.
        bus.AWVALID_i = 1'b0;
        bus.AWID_i    = 16'($urandom);
        bus.AWADDR_i  = $urandom;
        bus.AWLEN_i   = 8'($urandom);

        while (beat <= len && cyc < 4000) begin
            first = simul && beat == 0 && cyc == 0;
            wv = first ? 1'b1 : ($urandom_range(99) >= gap_pct);
            if (!first) begin
                d = $urandom;
                s = 4'($urandom);
            end
            bus.WVALID_i = wv;
            bus.WDATA_i  = d;
            bus.WSTRB_i  = s;
            bus.WLAST_i  = (beat == len) ^ (err_beat == int'(beat));
            @(negedge clk);
            n_checks++;
            if (bus.WREADY_o !== 1'b1 || bus.AWREADY_o !== 1'b0 || bus.BVALID_o !== 1'b0) begin
                n_errors++;
                $display("FAIL %s data_hs: wready %b awready %b bvalid %b want 1 0 0",
                         tag, bus.WREADY_o, bus.AWREADY_o, bus.BVALID_o);
            end
            n_checks++;
            if (we !== wv) begin
                n_errors++; $display("FAIL %s we: beat %0d got %b want %b", tag, beat, we, wv);
            end
            if (wv) begin
                n_checks++;
                if (word_addr !== model_word(addr) || wdata !== d || wstrb !== s) begin
                    n_errors++;
                    $display("FAIL %s beat_data: beat %0d addr %h data %h strb %h want %h %h %h",
                             tag, beat, word_addr, wdata, wstrb, model_word(addr), d, s);
                end
                if (bus.WLAST_i != (beat == len)) mism = 1'b1;
                beat++;
            end
            cyc++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (beat <= len) begin
            n_errors++; $display("FAIL %s beat_timeout: accepted %0d want %0d", tag, beat, len + 1);
        end

        // Response phase: offer AW and W traffic that must be ignored.
        eresp = model_bresp(mism);
        bus.WVALID_i  = 1'b1;
        bus.WDATA_i   = $urandom;
        bus.AWVALID_i = (bready_delay > 0);
        for (int unsigned k = 0; k <= bready_delay; k++) begin
            bus.BREADY_i = (k == bready_delay);
            @(negedge clk);
            n_checks++;
            if (bus.BVALID_o !== 1'b1 || bus.BID_o !== id || bus.BRESP_o !== eresp) begin
                n_errors++;
                $display("FAIL %s bresp: bvalid %b bid %h bresp %b want 1 %h %b",
                         tag, bus.BVALID_o, bus.BID_o, bus.BRESP_o, id, eresp);
            end
            n_checks++;
            if (bus.AWREADY_o !== 1'b0 || bus.WREADY_o !== 1'b0 || we !== 1'b0) begin
                n_errors++;
                $display("FAIL %s b_quiet: awready %b wready %b we %b want 0 0 0",
                         tag, bus.AWREADY_o, bus.WREADY_o, we);
            end
            @(posedge clk); #1;
        end
        bus.BREADY_i  = 1'b0;
        bus.AWVALID_i = 1'b0;
        bus.WVALID_i  = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.AWREADY_o !== 1'b1 || bus.BVALID_o !== 1'b0 || bus.WREADY_o !== 1'b0) begin
            n_errors++;
            $display("FAIL %s idle: awready %b bvalid %b wready %b want 1 0 0",
                     tag, bus.AWREADY_o, bus.BVALID_o, bus.WREADY_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        bus.AWID_i = '0; bus.AWADDR_i = '0; bus.AWLEN_i = '0; bus.AWSIZE_i = '0;
        bus.AWBURST_i = '0; bus.AWLOCK_i = 1'b0; bus.AWCACHE_i = '0; bus.AWPROT_i = '0;
        bus.AWREGION_i = '0; bus.AWUSER_i = '0; bus.AWQOS_i = '0; bus.AWVALID_i = 1'b0;
        bus.WDATA_i = '0; bus.WSTRB_i = '0; bus.WLAST_i = 1'b0; bus.WUSER_i = '0;
        bus.WVALID_i = 1'b0; bus.BREADY_i = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.AWREADY_o !== 1'b1 || bus.WREADY_o !== 1'b0 || bus.BVALID_o !== 1'b0 || we !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_hs: awready %b wready %b bvalid %b we %b want 1 0 0 0",
                     bus.AWREADY_o, bus.WREADY_o, bus.BVALID_o, we);
        end
        n_checks++;
        if (bus.BID_o !== 16'h0 || bus.BRESP_o !== 2'b00 || bus.BUSER_o !== 10'h0) begin
            n_errors++;
            $display("FAIL reset_b: bid %h bresp %b buser %h want 0 0 0", bus.BID_o, bus.BRESP_o, bus.BUSER_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        run_write(16'hA5C3, 32'h0000_000C, 0, -1, 0, 0, 1'b0, "single");
    endtask

    task automatic test_burst;
        // About half the cycles carry no beat, approximating a toggled WVALID.
        run_write(16'h1234, 32'h0000_0024, 3, -1, 50, 0, 1'b0, "burst");
        run_write(16'h0F0F, 32'hFFFF_FFFC, 255, -1, 0, 1, 1'b0, "burst256");
    endtask

    task automatic test_backpressure;
        run_write(16'hBEEF, 32'h0000_0010, 1, -1, 0, 5, 1'b0, "bp");
    endtask

    task automatic test_simultaneous;
        run_write(16'h0042, 32'h0000_0038, 0, -1, 0, 0, 1'b1, "simul");
    endtask

    task automatic test_reset_mid_burst;
        bus.AWID_i    = 16'h7777;
        bus.AWADDR_i  = 32'h0000_0014;
        bus.AWLEN_i   = 8'd7;
        bus.AWVALID_i = 1'b1;
        @(posedge clk); #1;
        bus.AWVALID_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.WVALID_i = 1'b1;
            bus.WDATA_i  = $urandom;
            @(negedge clk);
            n_checks++;
            if (we !== 1'b1) begin
                n_errors++; $display("FAIL midrst_beat: beat %0d we %b want 1", i, we);
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (we !== 1'b0 || bus.BVALID_o !== 1'b0 || bus.AWREADY_o !== 1'b1 || bus.WREADY_o !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_async: we %b bvalid %b awready %b wready %b want 0 0 1 0",
                     we, bus.BVALID_o, bus.AWREADY_o, bus.WREADY_o);
        end
        n_checks++;
        if (bus.BID_o !== 16'h0) begin
            n_errors++; $display("FAIL midrst_bid: got %h want 0000", bus.BID_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (we !== 1'b0 || bus.WREADY_o !== 1'b0 || bus.AWREADY_o !== 1'b1) begin
            n_errors++;
            $display("FAIL midrst_after: we %b wready %b awready %b want 0 0 1", we, bus.WREADY_o, bus.AWREADY_o);
        end
        @(posedge clk); #1;
        bus.WVALID_i = 1'b0;
        run_write(16'h3131, 32'h0000_0008, 2, -1, 20, 1, 1'b0, "postrst");
    endtask

    task automatic test_last_check;
        // WLAST on beat 0 of a 2-beat burst, then a clean burst.
        run_write(16'h5151, 32'h0000_001C, 1, 0, 0, 0, 1'b0, "lastbad");
        run_write(16'h5252, 32'h0000_001C, 1, -1, 0, 0, 1'b0, "lastok");
        run_write(16'h5353, 32'h0000_0000, 0, 0, 0, 0, 1'b0, "lastmiss");
    endtask

    task automatic test_random;
        for (int t = 0; t < 25; t++) begin
            int unsigned len;
            int          eb;
            len = ($urandom_range(3) == 0) ? $urandom_range(15) : $urandom_range(3);
            eb  = ($urandom_range(3) == 0) ? int'($urandom_range(len)) : -1;
            run_write(16'($urandom), $urandom, len, eb, 30, $urandom_range(3),
                      1'($urandom_range(1)), "rand");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_simultaneous();
        test_reset_mid_burst();
        test_last_check();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
